// File: rtl/cdc_pkg.sv
// Shared FSM type, default sizes and synchronizer-depth guard for the CDC transmitter.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ_HI      = 2'd1,
    WAIT_ACK_LO = 2'd2
  } txState_e;

  localparam int CDC_DATA_W          = 8;
  localparam int CDC_SYNC_STAGES     = 2;
  localparam int CDC_TIMEOUT_W       = 16;
  localparam int CDC_MIN_SYNC_STAGES = 2;

  // Fewer than two flops gives no metastability margin, so shallower requests are raised to the minimum.
  function automatic int syncDepth(input int requested);
    return (requested < CDC_MIN_SYNC_STAGES) ? CDC_MIN_SYNC_STAGES : requested;
  endfunction

endpackage

// File: rtl/ack_sync_chain.sv
// Flop chain that brings the remote acknowledge level into the clk domain.
module ack_sync_chain
  import cdc_pkg::*;
#(
  parameter int STAGES = CDC_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic asyncIn,
  output logic syncOut
);

  logic [STAGES-1:0] syncReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncReg <= '0;
    end else begin
      syncReg <= {syncReg[STAGES-2:0], asyncIn};
    end
  end

  assign syncOut = syncReg[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Four-phase req/ack transmitter handing one held word at a time to a remote clock domain.
// Define CDC_TX_TIMEOUT_EN to add a sticky acknowledge-timeout flag.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = CDC_DATA_W,
  parameter int SYNC_STAGES = CDC_SYNC_STAGES,
  parameter int TIMEOUT_W   = CDC_TIMEOUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  output logic              busy,
  output logic              err_timeout
);

  localparam int SyncDepth = syncDepth(SYNC_STAGES);

  txState_e state;
  logic     ackSync;
  logic     accept;

  ack_sync_chain #(.STAGES(SyncDepth)) ackSyncChain (
    .clk     (clk),
    .rst_n   (rst_n),
    .asyncIn (ack_in),
    .syncOut (ackSync)
  );

  // A stale acknowledge still visible after the last handshake blocks new words.
  assign in_ready = (state == IDLE) && !ackSync;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_out  <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_out <= in_data;
            req_out  <= 1'b1;
            state    <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (ackSync) begin
            req_out <= 1'b0;
            state   <= WAIT_ACK_LO;
          end
        end
        WAIT_ACK_LO: begin
          if (!ackSync) begin
            state <= IDLE;
          end
        end
        default: begin
          req_out <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TimeoutLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] timeoutCount;
  logic                 errSticky;
  logic                 stateAdvance;

  assign stateAdvance = accept
                     || ((state == REQ_HI) && ackSync)
                     || ((state == WAIT_ACK_LO) && !ackSync);

  // Counts dwell time in each waiting state; the flag never aborts the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeoutCount <= '0;
      errSticky    <= 1'b0;
    end else if (stateAdvance || !busy) begin
      timeoutCount <= '0;
    end else begin
      if (timeoutCount != '1) begin
        timeoutCount <= timeoutCount + TIMEOUT_W'(1);
      end
      if (timeoutCount == TimeoutLast) begin
        errSticky <= 1'b1;
      end
    end
  end

  assign err_timeout = errSticky;
`else
  // Monitor compiled out: the flag is tied low by a constant expression of the unused width.
  assign err_timeout = (TIMEOUT_W < 0);
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Randomized and directed bench for cdc_handshake_tx with a cycle-level reference model and word scoreboard.
module tb_cdc_handshake_tx;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TW = 4;
`ifdef CDC_TX_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          ack_in   = 1'b0;
  logic          in_ready, req_out, busy, err_timeout;
  logic [DW-1:0] data_out;

  int total = 0;
  int bad   = 0;

  cdc_handshake_tx #(.DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .req_out     (req_out),
    .data_out    (data_out),
    .ack_in      (ack_in),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  // Reference model: a transfer is open from acceptance until the remote ack has been
  // seen high and then low again, each seen through an SS-cycle sampling delay.
  bit            ackHist[$];
  bit            mBusy, mAckSeen, mErr;
  int            mPhaseCycles, mCycle, acceptCount;
  logic [DW-1:0] mData;
  logic [DW-1:0] expQ[$];
  int            acceptCycles[$];

  function automatic bit seenAck();
    return (ackHist.size() >= SS) ? ackHist[SS-1] : 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit seen, moved;
    if (!rst_n) begin
      ackHist.delete();
      expQ.delete();
      mBusy = 0; mAckSeen = 0; mErr = 0; mPhaseCycles = 0; mData = '0;
    end else begin
      mCycle++;
      seen  = seenAck();
      moved = 0;
      if (!mBusy) begin
        if (in_valid && !seen) begin
          mBusy = 1; mAckSeen = 0; mData = in_data; moved = 1;
          expQ.push_back(in_data);
          acceptCycles.push_back(mCycle);
          acceptCount++;
        end
      end else if (!mAckSeen) begin
        if (seen) begin mAckSeen = 1; moved = 1; end
      end else if (!seen) begin
        mBusy = 0; moved = 1;
      end
      if (moved || !mBusy) mPhaseCycles = 0;
      else begin
        mPhaseCycles++;
        if (TimeoutOn && mPhaseCycles == (1 << TW) - 1) mErr = 1;
      end
      ackHist.push_front(ack_in);
      if (ackHist.size() > SS) void'(ackHist.pop_back());
    end
  end

  // Monitor: lockstep comparison of every output plus scoreboard pop on each new request.
  int            reqRises = 0;
  logic          prevReq  = 1'b0;
  logic [DW-1:0] sbWord;

  always @(posedge clk) begin
    #1;
    checkOutput("in_ready", 32'(in_ready), 32'(!mBusy && !seenAck()));
    checkOutput("req_out", 32'(req_out), 32'(mBusy && !mAckSeen));
    checkOutput("busy", 32'(busy), 32'(mBusy));
    checkOutput("data_out", 32'(data_out), 32'(mData));
    checkOutput("err_timeout", 32'(err_timeout), 32'(mErr));
    if (req_out && !prevReq) begin
      reqRises++;
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_unexpected_req: got data 0x%0h, want no request at %0t", data_out, $time);
      end else begin
        sbWord = expQ.pop_front();
        if (data_out !== sbWord) begin
          bad++;
          $display("[TB] FAIL sb_word: got 0x%0h, want 0x%0h at %0t", data_out, sbWord, $time);
        end
      end
    end
    prevReq = req_out;
  end

  // Remote side: acknowledges and releases after a random number of cycles.
  bit autoAck     = 0;
  int ackDelayMax = 3;

  initial begin
    forever begin
      @(negedge clk);
      if (autoAck) begin
        if (req_out && !ack_in) begin
          repeat ($urandom_range(ackDelayMax, 0)) @(negedge clk);
          if (autoAck) ack_in = 1'b1;
        end else if (!req_out && ack_in) begin
          repeat ($urandom_range(ackDelayMax, 0)) @(negedge clk);
          if (autoAck) ack_in = 1'b0;
        end
      end
    end
  end

  task automatic waitAccept(input int target, input string tag);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (acceptCount >= target) begin ok = 1; break; end
    end
    checkOutput(tag, 32'(ok), 32'(1));
  endtask

  task automatic waitIdle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!mBusy) begin ok = 1; break; end
    end
    checkOutput(tag, 32'(ok), 32'(1));
  endtask

  task automatic edgesUntil(input bit wantReq, output int n);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (wantReq ? !req_out : in_ready) begin n = i; break; end
    end
  endtask

  initial begin
    int n, startAcc, rises0, gap;

    #1;
    checkOutput("rst_req_out", 32'(req_out), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_data_out", 32'(data_out), 32'(0));
    checkOutput("rst_err", 32'(err_timeout), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", 32'(in_ready), 32'(1));

    // Basic transfer with a hand-timed remote ack.
    @(negedge clk);
    startAcc = acceptCount;
    applyStimulus(1'b1, 8'hA5);
    waitAccept(startAcc + 1, "basic_accept");
    applyStimulus(1'b0, 8'h00);
    checkOutput("basic_data", 32'(data_out), 32'h0A5);
    checkOutput("basic_req", 32'(req_out), 32'(1));
    repeat (3) @(negedge clk);
    ack_in = 1'b1;
    edgesUntil(1'b1, n);
    checkOutput("req_fall_latency", 32'(n), 32'(SS + 1));
    @(negedge clk);
    ack_in = 1'b0;
    edgesUntil(1'b0, n);
    checkOutput("ready_return_latency", 32'(n), 32'(SS + 1));

    // Back-to-back words with in_valid held.
    @(negedge clk);
    autoAck = 1; ackDelayMax = 3;
    startAcc = acceptCount;
    rises0   = reqRises;
    applyStimulus(1'b1, 8'h01);
    waitAccept(startAcc + 1, "b2b_first_accept");
    applyStimulus(1'b1, 8'h02);
    waitAccept(startAcc + 2, "b2b_second_accept");
    applyStimulus(1'b0, 8'h00);
    waitIdle("b2b_idle");
    checkOutput("b2b_handshakes", 32'(reqRises - rises0), 32'(2));
    gap = acceptCycles[acceptCycles.size()-1] - acceptCycles[acceptCycles.size()-2];
    checkOutput("b2b_min_gap", 32'(gap >= 2*SS + 2), 32'(1));
    autoAck = 0;
    repeat (ackDelayMax + 3) @(negedge clk);

    // Reset during REQ_HI.
    startAcc = acceptCount;
    applyStimulus(1'b1, DW'($urandom));
    waitAccept(startAcc + 1, "rst_mid_accept");
    applyStimulus(1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_req_async", 32'(req_out), 32'(0));
    checkOutput("rst_mid_busy_async", 32'(busy), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rises0 = reqRises;
    repeat (8) @(negedge clk);
    checkOutput("rst_mid_no_replay", 32'(reqRises), 32'(rises0));

    // Stale ack at reset release.
    rst_n  = 1'b0;
    ack_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rises0   = reqRises;
    startAcc = acceptCount;
    repeat (SS + 1) @(negedge clk);
    applyStimulus(1'b1, 8'h5A);
    repeat (4) @(negedge clk);
    checkOutput("stale_ready_low", 32'(in_ready), 32'(0));
    checkOutput("stale_no_req", 32'(reqRises), 32'(rises0));
    ack_in = 1'b0;
    edgesUntil(1'b0, n);
    checkOutput("stale_ready_latency", 32'(n), 32'(SS));
    autoAck = 1;
    waitAccept(startAcc + 1, "stale_accept");
    applyStimulus(1'b0, 8'h00);
    waitIdle("stale_idle");
    autoAck = 0;
    repeat (ackDelayMax + 3) @(negedge clk);

    // Remote never answers until long after the timeout window.
    startAcc = acceptCount;
    applyStimulus(1'b1, DW'($urandom));
    waitAccept(startAcc + 1, "to_accept");
    applyStimulus(1'b0, 8'h00);
    repeat (14) @(negedge clk);
    checkOutput("to_err_before", 32'(err_timeout), 32'(0));
    @(negedge clk);
    checkOutput("to_err_at_limit", 32'(err_timeout), 32'(TimeoutOn));
    checkOutput("to_req_held", 32'(req_out), 32'(1));
    repeat (5) @(negedge clk);
    ack_in = 1'b1;
    edgesUntil(1'b1, n);
    checkOutput("to_late_ack_req_fall", 32'(n), 32'(SS + 1));
    @(negedge clk);
    ack_in = 1'b0;
    waitIdle("to_late_ack_idle");
    checkOutput("to_err_sticky", 32'(err_timeout), 32'(TimeoutOn));

    // Random traffic.
    autoAck = 1; ackDelayMax = 4;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      applyStimulus(logic'($urandom_range(1, 0)), DW'($urandom));
    end
    applyStimulus(1'b0, 8'h00);
    waitIdle("random_drain");
    repeat (4) @(negedge clk);
    checkOutput("sb_queue_empty", 32'(expQ.size()), 32'(0));
    checkOutput("req_count", 32'(reqRises), 32'(acceptCount));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish, want finish before 300000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
